// File: rtl/rca_add_seq.sv
// rca_add_seq: two-requester, byte-serial adder.
//
// One 8-bit ripple-carry adder is reused across NBYTES cycles, least
// significant byte first. The result is held until the consumer takes it.
//
// Parameters
//   NBYTES      operand width in bytes (2..8); W = 8*NBYTES
// Ports
//   clk         clock; all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   req0_*      requester 0: valid/ready, operands a/b (W bits), carry-in cin
//   req1_*      requester 1: same as requester 0
//   rsp_valid   result available (RESP state)
//   rsp_ready   consumer accepts the result
//   rsp_sum     a+b+cin modulo 2^W
//   rsp_cout    unsigned carry out of bit W-1
//   rsp_ovf     signed overflow
//   rsp_id      index of the requester that owns the result
//   busy        high whenever the FSM is not in IDLE
//   state       current FSM state, for debug visibility
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on the sink's own valid in a way that could
// form a loop, and req*_ready never depends on rsp_ready.

module ripple_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module rca_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  rsp_id,
  output logic                  busy,
  output logic [1:0]            state
);
  localparam int W = 8 * NBYTES;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] IDX_LAST = 3'(NBYTES - 1);

  // Operands shift right one byte per ADD cycle so the adder always sees
  // byte 0 of the shift registers; the sum shifts in from the top so that
  // after NBYTES cycles byte 0 of the result sits at the bottom.
  logic [W-1:0] a_sh;
  logic [W-1:0] b_sh;
  logic [W-1:0] sum_q;
  logic         carry;
  logic [2:0]   idx;
  logic         last_served;
  logic         id_q;
  logic         cout_q;
  logic         ovf_q;

  logic         grant0;
  logic         grant1;
  logic [7:0]   add_sum;
  logic         add_cout;

  ripple_adder_8bit u_adder (
    .a    (a_sh[7:0]),
    .b    (b_sh[7:0]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Round-robin on a tie: the requester not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_served)) grant0 = 1'b1;
      else if (req1_valid)                            grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_id     = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_q       <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      last_served <= 1'b1;
      id_q        <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_sh        <= grant1 ? req1_a   : req0_a;
            b_sh        <= grant1 ? req1_b   : req0_b;
            carry       <= grant1 ? req1_cin : req0_cin;
            id_q        <= grant1;
            last_served <= grant1;
            idx         <= '0;
            state       <= ADD;
          end
        end
        ADD: begin
          sum_q <= {add_sum, sum_q[W-1:8]};
          a_sh  <= a_sh >> 8;
          b_sh  <= b_sh >> 8;
          carry <= add_cout;
          idx   <= idx + 3'd1;
          if (idx == IDX_LAST) begin
            // On the top byte, bit 7 of the shifted operands is bit W-1;
            // a^b^sum there recovers the carry into the sign bit.
            cout_q <= add_cout;
            ovf_q  <= a_sh[7] ^ b_sh[7] ^ add_sum[7] ^ add_cout;
            state  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_add_seq.sv
// tb_rca_add_seq: directed, self-checking bench for rca_add_seq (NBYTES=4).
module tb_rca_add_seq;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_ovf, rsp_id, busy;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rca_add_seq #(.NBYTES(NBYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until rsp_valid, bounded; returns the count.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1;
    chk({tag, "_ready"}, 64'(id ? req1_ready : req0_ready), 64'(1));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    wait_rsp(n);
    chk({tag, "_lat"}, 64'(n), 64'(NBYTES));
    chk({tag, "_sum"}, 64'(rsp_sum), 64'(es));
    chk({tag, "_cout"}, 64'(rsp_cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(rsp_ovf), 64'(eo));
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    logic [W-1:0] tie_sum [2];

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;

    // Reset values
    #22;
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_sum",   64'(rsp_sum),   64'(0));
    chk("rst_cout",  64'(rsp_cout),  64'(0));
    chk("rst_ovf",   64'(rsp_ovf),   64'(0));
    chk("rst_id",    64'(rsp_id),    64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_rdy0",  64'(req0_ready), 64'(0));
    chk("rst_rdy1",  64'(req1_ready), 64'(0));
    rst_n = 1'b1;
    tick();

    // Carry out of byte 0
    do_op("byte_carry", 1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    // Carry ripples through every byte
    do_op("ripple_all", 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    // Signed overflow, positive direction
    do_op("ovf_pos",    1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    // Signed overflow, negative direction
    do_op("ovf_neg",    1'b1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);

    // Consumer stall: outputs hold, valids ignored, no early accept
    req1_valid = 1'b1; req1_a = 32'h00000010; req1_b = 32'h00000020; req1_cin = 1'b0;
    #1;
    chk("stall_ready", 64'(req1_ready), 64'(1));
    tick();
    req0_valid = 1'b1;
    wait_rsp(n);
    chk("stall_lat", 64'(n), 64'(NBYTES));
    for (int i = 0; i < 5; i++) begin
      chk("stall_sum",  64'(rsp_sum),    64'(32'h00000030));
      chk("stall_vld",  64'(rsp_valid),  64'(1));
      chk("stall_id",   64'(rsp_id),     64'(1));
      chk("stall_rdy0", 64'(req0_ready), 64'(0));
      chk("stall_rdy1", 64'(req1_ready), 64'(0));
      tick();
    end
    chk("stall_held", 64'(rsp_valid), 64'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("stall_release_busy", 64'(busy),       64'(0));
    chk("stall_release_vld",  64'(rsp_valid),  64'(0));
    chk("stall_next_rdy0",    64'(req0_ready), 64'(1));
    chk("stall_next_rdy1",    64'(req1_ready), 64'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    // Reset during ADD byte 2: abandoned, no response
    tick();
    req0_valid = 1'b1; req0_a = 32'h01020304; req0_b = 32'h10203040; req0_cin = 1'b0;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy),      64'(0));
    chk("arst_vld",  64'(rsp_valid), 64'(0));
    chk("arst_sum",  64'(rsp_sum),   64'(0));
    #2;
    rst_n = 1'b1;

    // Both requesters continuously valid: grants alternate 0,1,0,1
    req0_a = 32'h12345678; req0_b = 32'h11111111; req0_cin = 1'b0;
    req1_a = 32'hDEADBEEF; req1_b = 32'h01010101; req1_cin = 1'b1;
    tie_sum[0] = 32'h23456789;
    tie_sum[1] = 32'hDFAEBFF1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("tie_first_rdy0", 64'(req0_ready), 64'(1));
    chk("tie_first_rdy1", 64'(req1_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      wait_rsp(n);
      chk("tie_lat",  64'(n),        64'(NBYTES + 1));
      chk("tie_id",   64'(rsp_id),   64'(k % 2));
      chk("tie_sum",  64'(rsp_sum),  64'(tie_sum[k % 2]));
      chk("tie_cout", 64'(rsp_cout), 64'(0));
      chk("tie_ovf",  64'(rsp_ovf),  64'(0));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("end_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
